// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory access block: funct3 width codes,
// lane geometry, the write-buffer entry and the store lane-mask helper.
// The DMEM_INIT_EN build adds an INIT/RUN sequencer that zero-fills the array.
package dmem_pkg;

  localparam int DMEM_DATA_WIDTH    = 32;
  localparam int DMEM_BYTE_WIDTH    = 8;
  localparam int DMEM_ADDRESS_WIDTH = 9;
  localparam int LANES              = DMEM_DATA_WIDTH / DMEM_BYTE_WIDTH;
  localparam int WORD_AW            = DMEM_ADDRESS_WIDTH - 2;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef struct packed {
    logic                       valid;
    logic [WORD_AW-1:0]         word;
    logic [DMEM_DATA_WIDTH-1:0] data;
    logic [LANES-1:0]           mask;
  } wb_entry_t;

  typedef enum logic {ST_INIT, ST_RUN} init_state_t;

  // Byte lanes touched by a store; unsupported store widths touch nothing.
  function automatic logic [LANES-1:0] lane_mask(input logic [2:0] f3, input logic [1:0] a_lo);
    logic [LANES-1:0] m;
    m = '0;
    case (f3)
      F3_B:    m = 4'b0001 << a_lo;
      F3_H:    m = a_lo[1] ? 4'b1100 : 4'b0011;
      F3_W:    m = 4'b1111;
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/store_lane_align.sv
// Combinational store alignment: replicates store data across lanes, builds
// the lane mask and flags misaligned half/word accesses (loads and stores).
module store_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]                 funct3,
  input  logic [1:0]                 a_lo,
  input  logic [DMEM_DATA_WIDTH-1:0] wd,
  output logic [DMEM_DATA_WIDTH-1:0] data,
  output logic [LANES-1:0]           mask,
  output logic                       misaligned
);

  // Misaligned accesses never write, so their mask is forced empty.
  always_comb begin
    misaligned = 1'b0;
    data       = wd;
    case (funct3)
      F3_H, F3_HU: misaligned = a_lo[0];
      F3_W:        misaligned = (a_lo != 2'b00);
      default:     misaligned = 1'b0;
    endcase
    case (funct3)
      F3_B:    data = {LANES{wd[7:0]}};
      F3_H:    data = {2{wd[15:0]}};
      default: data = wd;
    endcase
    mask = misaligned ? '0 : lane_mask(funct3, a_lo);
  end

endmodule

// File: rtl/dmem_access.sv
// Byte-addressed data memory with a one-entry write buffer and
// store-to-load forwarding. Loads return the raw word one cycle later.
// Optional macro DMEM_INIT_EN: zero-fill the array after reset, busy meanwhile.
module dmem_access
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH    = DMEM_DATA_WIDTH,
  parameter int BYTE_WIDTH    = DMEM_BYTE_WIDTH,
  parameter int ADDRESS_WIDTH = DMEM_ADDRESS_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  input  logic                     req_we,
  input  logic [2:0]               funct3,
  input  logic [ADDRESS_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0]    WD,
  output logic                     rsp_valid,
  output logic [DATA_WIDTH-1:0]    RD,
  output logic [ADDRESS_WIDTH-1:0] A_out,
  output logic [2:0]               funct3_out,
  output logic                     misalign,
  output logic                     busy
);

  localparam int WAW   = ADDRESS_WIDTH - 2;
  localparam int DEPTH = 1 << WAW;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  wb_entry_t             wb;
  logic [WAW-1:0]        req_idx;
  logic [DATA_WIDTH-1:0] st_data;
  logic [LANES-1:0]      st_mask;
  logic                  mis_now;
  logic                  accept, load_acc, store_acc, drain;
  logic                  init_we;
  logic [WAW-1:0]        init_idx;
  logic                  mem_we;
  logic [WAW-1:0]        mem_idx;
  logic [DATA_WIDTH-1:0] mem_data;
  logic [LANES-1:0]      mem_mask;
  logic [DATA_WIDTH-1:0] rd_raw, fwd_data;
  logic [LANES-1:0]      fwd_mask;

  assign req_idx = A[ADDRESS_WIDTH-1:2];

  store_lane_align u_align (
    .funct3     (funct3),
    .a_lo       (A[1:0]),
    .wd         (WD),
    .data       (st_data),
    .mask       (st_mask),
    .misaligned (mis_now)
  );

`ifdef DMEM_INIT_EN
  init_state_t    state_q, state_d;
  logic [WAW-1:0] cnt_q, cnt_d;

  // Init sequencer state and word counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Zero one word per cycle while in INIT, leave after the last word.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    init_we = 1'b0;
    if (state_q == ST_INIT) begin
      init_we = 1'b1;
      cnt_d   = cnt_q + 1'b1;
      if (cnt_q == '1) state_d = ST_RUN;
    end
  end

  assign init_idx = cnt_q;
  assign busy     = (state_q == ST_INIT) && rst_n;
`else
  assign init_we  = 1'b0;
  assign init_idx = '0;
  assign busy     = 1'b0;
`endif

  assign accept    = req_valid && !busy;
  assign load_acc  = accept && !req_we;
  assign store_acc = accept && req_we && (st_mask != '0);
  assign drain     = wb.valid && !load_acc && !busy;

  assign mem_we   = rst_n && (init_we || drain);
  assign mem_idx  = init_we ? init_idx : wb.word;
  assign mem_data = init_we ? '0 : wb.data;
  assign mem_mask = init_we ? '1 : wb.mask;

  // Array write port: init fill or buffer drain, lane by lane.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < LANES; i++) begin
        if (mem_mask[i]) mem[mem_idx][i*BYTE_WIDTH +: BYTE_WIDTH] <= mem_data[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  // Write buffer: capture new stores, drop the entry once it has drained.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb <= '0;
    end else if (store_acc) begin
      wb <= '{valid: 1'b1, word: req_idx, data: st_data, mask: st_mask};
    end else if (drain) begin
      wb.valid <= 1'b0;
    end
  end

  // Load path: read the array and snapshot the matching buffer lanes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid  <= 1'b0;
      misalign   <= 1'b0;
      rd_raw     <= '0;
      fwd_data   <= '0;
      fwd_mask   <= '0;
      A_out      <= '0;
      funct3_out <= '0;
    end else begin
      rsp_valid <= load_acc;
      misalign  <= accept && mis_now;
      if (load_acc) begin
        rd_raw     <= mem[req_idx];
        fwd_data   <= wb.data;
        fwd_mask   <= (wb.valid && (wb.word == req_idx)) ? wb.mask : '0;
        A_out      <= A;
        funct3_out <= funct3;
      end
    end
  end

  // Overlay the forwarded buffer lanes onto the array word.
  always_comb begin
    RD = rd_raw;
    for (int i = 0; i < LANES; i++) begin
      if (fwd_mask[i]) RD[i*BYTE_WIDTH +: BYTE_WIDTH] = fwd_data[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

endmodule

// File: tb/tb_dmem_access.sv
// Scoreboard bench for dmem_access: stimulus pushes expected responses,
// an independent monitor pops and compares on every rising edge.
module tb_dmem_access;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_we;
  logic [2:0]  funct3;
  logic [8:0]  A;
  logic [31:0] WD;
  logic        rsp_valid;
  logic [31:0] RD;
  logic [8:0]  A_out;
  logic [2:0]  funct3_out;
  logic        misalign;
  logic        busy;

  int nChecks = 0;
  int nFails  = 0;

  typedef struct {
    logic [31:0] rd;
    logic [8:0]  a;
    logic [2:0]  f3;
  } rsp_t;

  typedef struct {
    logic rsp;
    logic mis;
  } cyc_t;

  rsp_t dataQ[$];
  cyc_t cycQ[$];

`ifdef DMEM_INIT_EN
  localparam logic [31:0] POST_RESET_50 = 32'h0000_0000;
`else
  localparam logic [31:0] POST_RESET_50 = 32'h0BAD_F00D;
`endif

  dmem_access dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .funct3     (funct3),
    .A          (A),
    .WD         (WD),
    .rsp_valid  (rsp_valid),
    .RD         (RD),
    .A_out      (A_out),
    .funct3_out (funct3_out),
    .misalign   (misalign),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // One request cycle; expected outcome queued for the monitor.
  task automatic applyStimulus(input logic v, input logic we, input logic [2:0] f3,
                               input logic [8:0] a, input logic [31:0] wd,
                               input logic [31:0] expRd, input logic expMis);
    cyc_t c;
    rsp_t r;
    @(negedge clk);
    req_valid = v;
    req_we    = we;
    funct3    = f3;
    A         = a;
    WD        = wd;
    c.rsp = v && !we;
    c.mis = expMis;
    cycQ.push_back(c);
    if (v && !we) begin
      r.rd = expRd;
      r.a  = a;
      r.f3 = f3;
      dataQ.push_back(r);
    end
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 3'b000, 9'h000, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic store(input logic [2:0] f3, input logic [8:0] a, input logic [31:0] wd, input logic expMis);
    applyStimulus(1'b1, 1'b1, f3, a, wd, 32'h0, expMis);
  endtask

  task automatic load(input logic [2:0] f3, input logic [8:0] a, input logic [31:0] expRd, input logic expMis);
    applyStimulus(1'b1, 1'b0, f3, a, 32'h0, expRd, expMis);
  endtask

  // Hold reset one edge, check cleared outputs, release and wait out init.
  task automatic doReset();
    int busyCycles;
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("reset_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    checkOutput("reset_RD", RD, 32'h0);
    checkOutput("reset_A_out", {23'b0, A_out}, 32'h0);
    checkOutput("reset_funct3_out", {29'b0, funct3_out}, 32'h0);
    checkOutput("reset_misalign", {31'b0, misalign}, 32'h0);
    checkOutput("reset_busy", {31'b0, busy}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    busyCycles = 0;
    while (busy && busyCycles < 1000) begin
      busyCycles++;
      @(posedge clk);
      #1;
    end
`ifdef DMEM_INIT_EN
    checkOutput("init_busy_cycles", busyCycles, 32'd128);
`else
    checkOutput("busy_after_reset", busyCycles, 32'd0);
`endif
  endtask

  // Monitor: per-cycle rsp_valid/misalign, and response data on rsp_valid.
  initial begin
    cyc_t c;
    rsp_t r;
    forever begin
      @(posedge clk);
      #1;
      if (cycQ.size() > 0) begin
        c = cycQ.pop_front();
        checkOutput("rsp_valid", {31'b0, rsp_valid}, {31'b0, c.rsp});
        checkOutput("misalign", {31'b0, misalign}, {31'b0, c.mis});
      end
      if (rsp_valid) begin
        if (dataQ.size() == 0) begin
          nChecks++;
          nFails++;
          $display("[TB] FAIL unexpected_rsp: rsp_valid=1 with no load outstanding at %0t", $time);
        end else begin
          r = dataQ.pop_front();
          checkOutput("RD", RD, r.rd);
          checkOutput("A_out", {23'b0, A_out}, {23'b0, r.a});
          checkOutput("funct3_out", {29'b0, funct3_out}, {29'b0, r.f3});
        end
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    funct3    = 3'b000;
    A         = 9'h000;
    WD        = 32'h0;
    repeat (2) @(posedge clk);
    doReset();

`ifdef DMEM_INIT_EN
    load(3'b010, 9'h1FC, 32'h0000_0000, 1'b0);
    idle();
`endif

    // Known background words for later reads.
    store(3'b010, 9'h044, 32'h1234_5678, 1'b0);
    store(3'b010, 9'h050, 32'h0BAD_F00D, 1'b0);
    idle();

    // Forwarded full word.
    store(3'b010, 9'h010, 32'hDEAD_BEEF, 1'b0);
    load(3'b010, 9'h010, 32'hDEAD_BEEF, 1'b0);
    idle();

    // Byte merge through the array, then half forwarded over it.
    store(3'b010, 9'h020, 32'h1122_3344, 1'b0);
    idle();
    store(3'b000, 9'h022, 32'h0000_00AB, 1'b0);
    idle();
    load(3'b010, 9'h020, 32'h11AB_3344, 1'b0);
    load(3'b100, 9'h023, 32'h11AB_3344, 1'b0);
    store(3'b001, 9'h022, 32'h0000_BEEF, 1'b0);
    load(3'b010, 9'h020, 32'hBEEF_3344, 1'b0);
    idle();

    // Misaligned store writes nothing; misaligned load still answers.
    store(3'b010, 9'h030, 32'h0000_0000, 1'b0);
    idle();
    store(3'b001, 9'h031, 32'h0000_BEEF, 1'b1);
    load(3'b010, 9'h030, 32'h0000_0000, 1'b0);
    load(3'b010, 9'h032, 32'h0000_0000, 1'b1);
    idle();

    // Buffer persists under back-to-back loads, then drains.
    store(3'b010, 9'h040, 32'hCAFE_F00D, 1'b0);
    load(3'b010, 9'h044, 32'h1234_5678, 1'b0);
    load(3'b010, 9'h044, 32'h1234_5678, 1'b0);
    load(3'b010, 9'h044, 32'h1234_5678, 1'b0);
    load(3'b010, 9'h040, 32'hCAFE_F00D, 1'b0);
    idle();
    load(3'b010, 9'h040, 32'hCAFE_F00D, 1'b0);

    // Unsupported store width is a no-op.
    store(3'b100, 9'h044, 32'hFFFF_FFFF, 1'b0);
    idle();
    load(3'b010, 9'h044, 32'h1234_5678, 1'b0);
    idle();

    // Reset discards a buffered store.
    store(3'b010, 9'h050, 32'h5555_AAAA, 1'b0);
    cycQ.delete();
    doReset();
    load(3'b010, 9'h050, POST_RESET_50, 1'b0);
    idle();
    idle();
    idle();

    checkOutput("responses_outstanding", dataQ.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/dmem_access.md
Name: dmem_access

Overview:
- Byte-addressed synchronous data memory for the RISC-V core. Sits directly upstream of the load-extension stage.
- Performs sb/sh/sw stores with byte-lane masking through a one-entry write buffer with store-to-load forwarding.
- Returns the raw aligned word (RD), plus the registered address and funct3, one cycle after a load, so the load stage can extract and extend it.

Parameters:
- DATA_WIDTH, 32, word width in bits.
- BYTE_WIDTH, 8, lane width in bits.
- ADDRESS_WIDTH, 9, byte-address width. Array depth is 2^(ADDRESS_WIDTH-2) words.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- req_valid  in  1  access request this cycle.
- req_we  in  1  1 = store, 0 = load.
- funct3  in  3  RISC-V width code (000 b, 001 h, 010 w, 100 bu, 101 hu).
- A  in  ADDRESS_WIDTH  byte address.
- WD  in  DATA_WIDTH  store data, right-justified.
- rsp_valid  out  1  RD/A_out/funct3_out valid (load response).
- RD  out  DATA_WIDTH  raw aligned word containing A.
- A_out  out  ADDRESS_WIDTH  registered load address.
- funct3_out  out  3  registered load funct3.
- misalign  out  1  one-cycle pulse: previous request misaligned.
- busy  out  1  block not accepting requests (init only).

Behaviour:
- Reset, synchronous on rst_n=0:
  - rsp_valid=0, RD=0, A_out=0, funct3_out=0, misalign=0, busy=0.
  - Write buffer invalidated. A pending buffered store is discarded (reset mid-operation loses it).
  - Array contents are not reset.
- Word index = A[ADDRESS_WIDTH-1:2], so addresses wrap naturally within the array.
- Lane mask for stores:
  - sb: 0001<<A[1:0]; WD[7:0] replicated to all lanes.
  - sh: A[1] ? 1100 : 0011; WD[15:0] replicated to both halves.
  - sw: 1111.
  - Other funct3 with req_we=1: treated as no-op.
- Misalignment:
  - sh/lh/lhu with A[0]=1, or sw/lw with A[1:0]!=0.
  - Misaligned store performs no write.
  - Misaligned load still reads the word and responds normally.
  - misalign is registered and pulses 1 in the cycle after the request.
- Single-port array: one read or one write per cycle.
- Store accepted (req_valid & req_we, aligned):
  - If the buffer holds an older entry, that entry drains to the array this cycle (port is free).
  - The new entry {word, data, mask} loads into the buffer. Stores are never stalled.
- Load accepted:
  - Array read this cycle. No drain.
  - Next cycle: rsp_valid=1, and RD = array word with buffered lanes overlaid wherever the buffer is valid and its word matches.
  - Load-to-response latency is 1 cycle. Back-to-back loads give back-to-back responses.
- Idle cycle (no req_valid): a valid buffer drains to the array and wb_valid clears.
- A buffer entry may persist indefinitely under continuous loads. Forwarding keeps results correct.
- rsp_valid is 0 in any cycle not following an accepted load. RD, A_out and funct3_out hold their last values when rsp_valid=0.
- Requests with busy=1 are ignored.

Optional Feature:
- Macro DMEM_INIT_EN.
- Defined: two-state FSM INIT→RUN.
  - On reset release, enter INIT with busy=1.
  - An ADDRESS_WIDTH-2-bit counter writes zero to one word per cycle, 2^(ADDRESS_WIDTH-2) cycles (128 by default).
  - The last word transitions to RUN and busy=0.
  - Reset during INIT restarts the counter at 0.
- Undefined: no FSM; busy tied 0; array initial contents undefined.

Decomposition:
- Package dmem_pkg:
  - funct3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - Lane-mask width constant.
  - typedef struct wb_entry_t {valid, word index, data, mask}.
  - Function for lane-mask generation.
- Sub-module store_lane_align (combinational): funct3, A[1:0], WD → replicated data, lane mask, misaligned flag.
- Array, buffer, forwarding merge and init FSM live in dmem_access.

Test Plan:
- sw 0xDEADBEEF @0x010, then lw @0x010 next cycle → one cycle later rsp_valid=1, RD=0xDEADBEEF (forwarded), A_out=0x010.
- sw 0x11223344 @0x020, idle, sb 0x000000AB @0x022, idle, lw @0x020 → RD=0x11AB3344.
- sw 0x0 @0x030, idle, sh 0xBEEF @0x031 → misalign=1 next cycle; then lw @0x030 → RD=0x00000000.
- sw 0xCAFEF00D @0x040, then lw @0x044 ×3 back-to-back, then lw @0x040 → three responses on consecutive cycles, then RD=0xCAFEF00D; after one idle cycle, lw @0x040 still returns 0xCAFEF00D from the array.
- sw 0x5555AAAA @0x050, rst_n=0 next cycle, release, lw @0x050 → rsp_valid=0 during reset; returns the pre-store contents.
- DMEM_INIT_EN: release reset → busy=1 for exactly 128 cycles; then lw @0x1FC → RD=0x00000000.
